reg_pipe_elastic: RTL and testbench

//   Parametrised multi-stage pipeline register with a valid/ready handshake.

---
 rtl/reg_pipe_elastic_if.sv | 33 +++
 rtl/reg_pipe_elastic.sv | 86 ++++++++
 tb/tb_reg_pipe_elastic.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_pipe_elastic_if.sv
// Valid/ready handshake bundle for reg_pipe_elastic: upstream push side,
// downstream pop side and the global enable.
interface reg_pipe_elastic_if #(
  parameter int N = 16
) ();
  logic         EN;
  logic         R_IN;
  logic [N-1:0] D_IN;
  logic         A_OUT;
  logic         R_OUT;
  logic [N-1:0] D_OUT;
  logic         A_IN;

  modport master (
    output EN,
    output R_IN,
    output D_IN,
    output A_IN,
    input  A_OUT,
    input  R_OUT,
    input  D_OUT
  );

  modport slave (
    input  EN,
    input  R_IN,
    input  D_IN,
    input  A_IN,
    output A_OUT,
    output R_OUT,
    output D_OUT
  );
endinterface

// File: rtl/reg_pipe_elastic.sv
// Elastic DEPTH-stage valid/ready register pipe with bubble collapse and global stall.
// Optional occupancy output COUNT is enabled by defining REG_PIPE_COUNT_EN.
module reg_pipe_elastic #(
  parameter int           N     = 16,
  parameter int           DEPTH = 2,
  parameter logic [N-1:0] I     = '0
) (
  input  logic CLK,
  input  logic RST,
  reg_pipe_elastic_if.slave pipe
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
`endif
);

  logic [DEPTH-1:0] vld_p;
  logic [N-1:0]     dat_p [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic             nxt_free;

  // Ready ripples from the output stage back to stage 0 within one cycle
  always_comb begin
    adv      = '0;
    ld       = '0;
    nxt_free = pipe.A_IN;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]   = pipe.EN & vld_p[k] & nxt_free;
      ld[k]    = pipe.EN & (~vld_p[k] | adv[k]);
      nxt_free = ~vld_p[k] | adv[k];
    end
  end

  // Stage registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p <= '0;
      for (int k = 0; k < DEPTH; k++) dat_p[k] <= I;
    end else begin
      if (ld[0]) begin
        vld_p[0] <= pipe.R_IN;
        if (pipe.R_IN) dat_p[0] <= pipe.D_IN;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          vld_p[k] <= vld_p[k-1] & adv[k-1];
          if (vld_p[k-1] & adv[k-1]) dat_p[k] <= dat_p[k-1];
        end
      end
    end
  end

  assign pipe.A_OUT = ~RST & ld[0];
  assign pipe.R_OUT = pipe.EN & vld_p[DEPTH-1];
  assign pipe.D_OUT = dat_p[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] cnt_q;

  function automatic logic [CW-1:0] occ_next(input logic [CW-1:0] occ,
                                             input logic inc, input logic dec);
    logic [CW-1:0] res;
    res = occ;
    if (inc && !dec && occ != CW'(DEPTH)) res = occ + CW'(1);
    else if (dec && !inc && occ != '0)    res = occ - CW'(1);
    return res;
  endfunction

  assign in_xfer  = pipe.R_IN & pipe.A_OUT;
  assign out_xfer = pipe.R_OUT & pipe.A_IN;

  // Occupancy register
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= occ_next(cnt_q, in_xfer, out_xfer);
  end

  assign COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Directed bench for reg_pipe_elastic: a DEPTH=2 and a DEPTH=3 instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_reg_pipe_elastic;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reg_pipe_elastic_if #(.N(16)) p2 ();
  reg_pipe_elastic_if #(.N(16)) p3 ();

`ifdef REG_PIPE_COUNT_EN
  logic [1:0] cnt2;
  logic [1:0] cnt3;
`endif

  reg_pipe_elastic #(.N(16), .DEPTH(2), .I(16'h0000)) u_dut2 (
    .CLK  (clk),
    .RST  (rst),
    .pipe (p2)
`ifdef REG_PIPE_COUNT_EN
    ,
    .COUNT(cnt2)
`endif
  );

  reg_pipe_elastic #(.N(16), .DEPTH(3), .I(16'h0000)) u_dut3 (
    .CLK  (clk),
    .RST  (rst),
    .pipe (p3)
`ifdef REG_PIPE_COUNT_EN
    ,
    .COUNT(cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p2.EN = 1'b1; p2.R_IN = 1'b1; p2.D_IN = 16'hFFFF; p2.A_IN = 1'b0;
    p3.EN = 1'b1; p3.R_IN = 1'b1; p3.D_IN = 16'hFFFF; p3.A_IN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      n_tests++;
      if (p2.A_OUT !== 1'b0) begin
        n_fail++; $display("FAIL reset_a_out_d2 cycle %0d: got %b want 0", i, p2.A_OUT);
      end
      n_tests++;
      if (p3.A_OUT !== 1'b0) begin
        n_fail++; $display("FAIL reset_a_out_d3 cycle %0d: got %b want 0", i, p3.A_OUT);
      end
    end
    cyc();
    rst = 1'b0; p2.R_IN = 1'b0; p3.R_IN = 1'b0;
    #1;
    n_tests++;
    if (p2.R_OUT !== 1'b0) begin
      n_fail++; $display("FAIL reset_r_out: got %b want 0", p2.R_OUT);
    end
    n_tests++;
    if (p2.D_OUT !== 16'h0000) begin
      n_fail++; $display("FAIL reset_d_out: got %h want 0000", p2.D_OUT);
    end
    n_tests++;
    if (p2.A_OUT !== 1'b1) begin
      n_fail++; $display("FAIL reset_a_out_after: got %b want 1", p2.A_OUT);
    end
    n_tests++;
    if (p3.R_OUT !== 1'b0 || p3.D_OUT !== 16'h0000 || p3.A_OUT !== 1'b1) begin
      n_fail++; $display("FAIL reset_d3: got r=%b d=%h a=%b want r=0 d=0000 a=1",
                         p3.R_OUT, p3.D_OUT, p3.A_OUT);
    end
`ifdef REG_PIPE_COUNT_EN
    n_tests++;
    if (cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", cnt2);
    end
`endif
  endtask

  task automatic test_latency();
    cyc();
    p3.A_IN = 1'b1; p3.R_IN = 1'b1; p3.D_IN = 16'hA5A5;
    #1;
    n_tests++;
    if (p3.A_OUT !== 1'b1 || p3.R_OUT !== 1'b0) begin
      n_fail++; $display("FAIL latency_c0: got a=%b r=%b want a=1 r=0", p3.A_OUT, p3.R_OUT);
    end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      p3.R_IN = 1'b0; p3.D_IN = 16'h0000;
      #1;
      n_tests++;
      if (p3.R_OUT !== (c == 3)) begin
        n_fail++; $display("FAIL latency_r_out cycle %0d: got %b want %b", c, p3.R_OUT, (c == 3));
      end
      if (c == 3) begin
        n_tests++;
        if (p3.D_OUT !== 16'hA5A5) begin
          n_fail++; $display("FAIL latency_d_out: got %h want a5a5", p3.D_OUT);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    p2.A_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      p2.R_IN = 1'b1; p2.D_IN = 16'(i + 1);
      #1;
      n_tests++;
      if (p2.A_OUT !== (i < 2)) begin
        n_fail++; $display("FAIL bp_a_out push %0d: got %b want %b", i, p2.A_OUT, (i < 2));
      end
    end
`ifdef REG_PIPE_COUNT_EN
    n_tests++;
    if (cnt2 !== 2'd2) begin
      n_fail++; $display("FAIL bp_count_full: got %0d want 2", cnt2);
    end
`endif
    // Release: word 3 is still offered and enters as word 1 leaves
    for (int i = 0; i < 4; i++) begin
      cyc();
      p2.A_IN = 1'b1;
      if (i > 0) p2.R_IN = 1'b0;
      #1;
      n_tests++;
      if (p2.R_OUT !== (i < 3)) begin
        n_fail++; $display("FAIL bp_r_out drain %0d: got %b want %b", i, p2.R_OUT, (i < 3));
      end
      if (i < 3) begin
        n_tests++;
        if (p2.D_OUT !== 16'(i + 1)) begin
          n_fail++; $display("FAIL bp_order drain %0d: got %h want %h", i, p2.D_OUT, 16'(i + 1));
        end
      end
      if (i == 0) begin
        n_tests++;
        if (p2.A_OUT !== 1'b1) begin
          n_fail++; $display("FAIL bp_full_passthru_a_out: got %b want 1", p2.A_OUT);
        end
      end
    end
  endtask

  task automatic test_streaming();
    p2.A_IN = 1'b1; p2.EN = 1'b1;
    for (int c = 0; c < 104; c++) begin
      cyc();
      p2.R_IN = (c < 100);
      p2.D_IN = (c < 100) ? 16'(16'h1000 + c) : 16'h0000;
      #1;
      if (c < 100) begin
        n_tests++;
        if (p2.A_OUT !== 1'b1) begin
          n_fail++; $display("FAIL stream_a_out cycle %0d: got %b want 1", c, p2.A_OUT);
        end
      end
      n_tests++;
      if (p2.R_OUT !== (c >= 2 && c < 102)) begin
        n_fail++; $display("FAIL stream_r_out cycle %0d: got %b want %b", c, p2.R_OUT,
                           (c >= 2 && c < 102));
      end
      if (c >= 2 && c < 102) begin
        n_tests++;
        if (p2.D_OUT !== 16'(16'h1000 + c - 2)) begin
          n_fail++; $display("FAIL stream_d_out cycle %0d: got %h want %h", c, p2.D_OUT,
                             16'(16'h1000 + c - 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    p2.A_IN = 1'b0;
    cyc(); p2.R_IN = 1'b1; p2.D_IN = 16'h0011;
    cyc(); p2.R_IN = 1'b1; p2.D_IN = 16'h0022;
    for (int i = 0; i < 5; i++) begin
      cyc();
      p2.EN = 1'b0; p2.A_IN = 1'b1; p2.R_IN = 1'b1; p2.D_IN = 16'h00FF;
      #1;
      n_tests++;
      if (p2.R_OUT !== 1'b0 || p2.A_OUT !== 1'b0) begin
        n_fail++; $display("FAIL stall_handshake cycle %0d: got r=%b a=%b want r=0 a=0",
                           i, p2.R_OUT, p2.A_OUT);
      end
      n_tests++;
      if (p2.D_OUT !== 16'h0011) begin
        n_fail++; $display("FAIL stall_d_hold cycle %0d: got %h want 0011", i, p2.D_OUT);
      end
`ifdef REG_PIPE_COUNT_EN
      n_tests++;
      if (cnt2 !== 2'd2) begin
        n_fail++; $display("FAIL stall_count cycle %0d: got %0d want 2", i, cnt2);
      end
`endif
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      p2.EN = 1'b1; p2.R_IN = 1'b0; p2.D_IN = 16'h0000;
      #1;
      n_tests++;
      if (p2.R_OUT !== (i < 2)) begin
        n_fail++; $display("FAIL stall_resume_r_out %0d: got %b want %b", i, p2.R_OUT, (i < 2));
      end
      if (i < 2) begin
        n_tests++;
        if (p2.D_OUT !== ((i == 0) ? 16'h0011 : 16'h0022)) begin
          n_fail++; $display("FAIL stall_resume_d_out %0d: got %h want %h", i, p2.D_OUT,
                             ((i == 0) ? 16'h0011 : 16'h0022));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    p2.A_IN = 1'b0;
    cyc(); p2.R_IN = 1'b1; p2.D_IN = 16'h0A0A;
    cyc(); p2.R_IN = 1'b1; p2.D_IN = 16'h0B0B;
    cyc();
    rst = 1'b1; p2.R_IN = 1'b0;
    #1;
    n_tests++;
    if (p2.A_OUT !== 1'b0) begin
      n_fail++; $display("FAIL midrst_a_out: got %b want 0", p2.A_OUT);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      rst = 1'b0; p2.A_IN = 1'b1;
      #1;
      n_tests++;
      if (p2.R_OUT !== 1'b0) begin
        n_fail++; $display("FAIL midrst_r_out cycle %0d: got %b want 0 (d=%h)", i, p2.R_OUT, p2.D_OUT);
      end
    end
    n_tests++;
    if (p2.D_OUT !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_d_out: got %h want 0000", p2.D_OUT);
    end
`ifdef REG_PIPE_COUNT_EN
    n_tests++;
    if (cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL midrst_count: got %0d want 0", cnt2);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_streaming();
    test_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
